// File: rtl/vga_fb_arbiter.sv
// Single-port frame-buffer arbiter: display reads win by default, the host is
// forced through after MAX_WAIT starved cycles at the cost of one display slot.
module vga_fb_arbiter #(
    parameter int ADDR_W   = 19,
    parameter int DATA_W   = 16,
    parameter int MAX_WAIT = 16
) (
    input  logic              vga_clk,
    input  logic              reset,
    input  logic              disp_req,
    input  logic [ADDR_W-1:0] disp_addr,
    output logic              disp_valid,
    output logic [DATA_W-1:0] disp_data,
    input  logic              host_valid,
    output logic              host_ready,
    input  logic              host_we,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [DATA_W-1:0] host_wdata,
    output logic              host_rvalid,
    output logic [DATA_W-1:0] host_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              clr_stats,
    output logic [15:0]       underrun_cnt
);

    localparam logic [7:0] WAIT_LIMIT = 8'(MAX_WAIT - 1);

    typedef enum logic [1:0] {GNT_IDLE, GNT_DISP, GNT_HOST, GNT_FORCE} grant_t;
    typedef enum logic [1:0] {TAG_NONE, TAG_DISP, TAG_HREAD, TAG_DROP} tag_t;

    grant_t            grant;
    tag_t              tag_next;
    logic              host_xfer;
    logic              drop_next;

    tag_t              tag_s1_reg;
    logic              drop_s1_reg;
    logic              disp_valid_reg;
    logic [DATA_W-1:0] disp_data_reg;
    logic              host_rvalid_reg;
    logic [DATA_W-1:0] host_rdata_reg;
    logic [7:0]        wait_cnt_reg;
    logic              force_pend_reg;
    logic [15:0]       underrun_cnt_reg;

    // Grant is gated by reset so every combinational output is 0 while reset is high.
    always_comb begin
        grant = GNT_IDLE;
        if (!reset) begin
            if (force_pend_reg && host_valid) begin
                grant = GNT_FORCE;
            end else if (disp_req) begin
                grant = GNT_DISP;
            end else if (host_valid) begin
                grant = GNT_HOST;
            end
        end
    end

    assign host_xfer  = (grant == GNT_HOST) || (grant == GNT_FORCE);
    assign drop_next  = (grant == GNT_FORCE) && disp_req;
    assign host_ready = host_xfer;

    // A forced host read during a display slot needs both a read tag and a
    // dropped slot, so the drop is carried alongside the tag as its own bit.
    always_comb begin
        tag_next = TAG_NONE;
        if (grant == GNT_DISP) begin
            tag_next = TAG_DISP;
        end else if (host_xfer && !host_we) begin
            tag_next = TAG_HREAD;
        end else if (drop_next) begin
            tag_next = TAG_DROP;
        end
    end

    always_comb begin
        mem_en    = (grant != GNT_IDLE);
        mem_we    = host_xfer && host_we;
        mem_addr  = '0;
        mem_wdata = '0;
        if (grant == GNT_DISP) begin
            mem_addr = disp_addr;
        end else if (host_xfer) begin
            mem_addr  = host_addr;
            mem_wdata = host_wdata;
        end
    end

    always_ff @(posedge vga_clk or posedge reset) begin
        if (reset) begin
            tag_s1_reg       <= TAG_NONE;
            drop_s1_reg      <= 1'b0;
            disp_valid_reg   <= 1'b0;
            disp_data_reg    <= '0;
            host_rvalid_reg  <= 1'b0;
            host_rdata_reg   <= '0;
            wait_cnt_reg     <= '0;
            force_pend_reg   <= 1'b0;
            underrun_cnt_reg <= '0;
        end else begin
            tag_s1_reg  <= tag_next;
            drop_s1_reg <= drop_next;

            // A dropped slot still produces a strobe so the display timing stays intact.
            disp_valid_reg <= (tag_s1_reg == TAG_DISP) || drop_s1_reg;
            if (tag_s1_reg == TAG_DISP) begin
                disp_data_reg <= mem_rdata;
            end
            host_rvalid_reg <= (tag_s1_reg == TAG_HREAD);
            if (tag_s1_reg == TAG_HREAD) begin
                host_rdata_reg <= mem_rdata;
            end

            if (!host_valid) begin
                wait_cnt_reg   <= '0;
                force_pend_reg <= 1'b0;
            end else if (host_xfer) begin
                wait_cnt_reg <= '0;
                if (grant == GNT_FORCE) begin
                    force_pend_reg <= 1'b0;
                end
            end else begin
                if (wait_cnt_reg == WAIT_LIMIT) begin
                    force_pend_reg <= 1'b1;
                end
                if (wait_cnt_reg != 8'hFF) begin
                    wait_cnt_reg <= wait_cnt_reg + 8'd1;
                end
            end

            if (clr_stats) begin
                underrun_cnt_reg <= '0;
            end else if (drop_next && (underrun_cnt_reg != 16'hFFFF)) begin
                underrun_cnt_reg <= underrun_cnt_reg + 16'd1;
            end
        end
    end

    assign disp_valid   = disp_valid_reg;
    assign disp_data    = disp_data_reg;
    assign host_rvalid  = host_rvalid_reg;
    assign host_rdata   = host_rdata_reg;
    assign underrun_cnt = underrun_cnt_reg;

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Directed and random stimulus for vga_fb_arbiter, checked every cycle against
// a transaction-level model of the arbitration and response rules.
module tb_vga_fb_arbiter;

    localparam int AW = 19;
    localparam int DW = 16;
    localparam int MW = 16;

    logic          vga_clk = 1'b0;
    logic          reset;
    logic          disp_req;
    logic [AW-1:0] disp_addr;
    logic          disp_valid;
    logic [DW-1:0] disp_data;
    logic          host_valid;
    logic          host_ready;
    logic          host_we;
    logic [AW-1:0] host_addr;
    logic [DW-1:0] host_wdata;
    logic          host_rvalid;
    logic [DW-1:0] host_rdata;
    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata = '0;
    logic          clr_stats;
    logic [15:0]   underrun_cnt;

    always #5 vga_clk = ~vga_clk;

    vga_fb_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_WAIT(MW)) dut (
        .vga_clk(vga_clk), .reset(reset),
        .disp_req(disp_req), .disp_addr(disp_addr),
        .disp_valid(disp_valid), .disp_data(disp_data),
        .host_valid(host_valid), .host_ready(host_ready), .host_we(host_we),
        .host_addr(host_addr), .host_wdata(host_wdata),
        .host_rvalid(host_rvalid), .host_rdata(host_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .clr_stats(clr_stats), .underrun_cnt(underrun_cnt)
    );

    // Frame-buffer memory driven by the DUT's memory port; unwritten words read addr+0x100.
    logic [15:0] mem [int];
    always @(posedge vga_clk) begin
        if (mem_en) begin
            mem_rdata <= mem.exists(int'(mem_addr[7:0])) ? mem[int'(mem_addr[7:0])]
                                                        : 16'h0100 + 16'(mem_addr[7:0]);
            if (mem_we) mem[int'(mem_addr[7:0])] = mem_wdata;
        end
    end

    typedef struct { int due; bit drop; logic [15:0] data; } dev_t;
    typedef struct { int due; logic [15:0] data; } hev_t;

    logic [15:0] ref_mem [int];
    dev_t        dq[$];
    hev_t        hq[$];
    logic [15:0] obs_disp[$];
    logic [15:0] obs_host[$];
    int          cyc = 0;
    int          wcnt_m = 0;
    bit          pend_m = 0;
    logic [15:0] under_m = '0;
    logic [15:0] disp_data_m = '0;
    logic [15:0] host_rdata_m = '0;
    int          ready_seen = 0;
    int          vectors = 0;
    int          miscompares = 0;

    function automatic logic [15:0] rd_ref(input logic [AW-1:0] a);
        return ref_mem.exists(int'(a[7:0])) ? ref_mem[int'(a[7:0])] : 16'h0100 + 16'(a[7:0]);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // One clock cycle: drive inputs, check outputs against the model, then advance the model.
    task automatic step(input bit rst, input bit dr, input logic [AW-1:0] da, input bit hv,
                        input bit hwe, input logic [AW-1:0] ha, input logic [DW-1:0] hwd,
                        input bit clr);
        int   g;
        bit   exp_dv, exp_hv;
        dev_t d;
        hev_t h;
        @(posedge vga_clk);
        #1;
        reset = rst; disp_req = dr; disp_addr = da; host_valid = hv; host_we = hwe;
        host_addr = ha; host_wdata = hwd; clr_stats = clr;
        cyc++;
        #1;
        if (rst) begin
            dq.delete(); hq.delete();
            wcnt_m = 0; pend_m = 0; under_m = '0; disp_data_m = '0; host_rdata_m = '0;
            chk("rst_flags", {27'd0, disp_valid, host_ready, host_rvalid, mem_en, mem_we}, 0);
            chk("rst_data", {disp_data, host_rdata}, 0);
            chk("rst_mem_addr", 32'(mem_addr), 0);
            chk("rst_mem_wdata", 32'(mem_wdata), 0);
            chk("rst_underrun", 32'(underrun_cnt), 0);
            return;
        end

        exp_dv = 0;
        if (dq.size() > 0 && dq[0].due == cyc) begin
            d = dq.pop_front();
            exp_dv = 1;
            if (!d.drop) disp_data_m = d.data;
        end
        exp_hv = 0;
        if (hq.size() > 0 && hq[0].due == cyc) begin
            h = hq.pop_front();
            exp_hv = 1;
            host_rdata_m = h.data;
        end
        chk("disp_valid", 32'(disp_valid), 32'(exp_dv));
        chk("disp_data", 32'(disp_data), 32'(disp_data_m));
        chk("host_rvalid", 32'(host_rvalid), 32'(exp_hv));
        chk("host_rdata", 32'(host_rdata), 32'(host_rdata_m));
        chk("underrun_cnt", 32'(underrun_cnt), 32'(under_m));
        if (disp_valid) obs_disp.push_back(disp_data);
        if (host_rvalid) obs_host.push_back(host_rdata);

        // 0 idle, 1 display, 2 host, 3 forced host
        if (pend_m && hv) g = 3;
        else if (dr)      g = 1;
        else if (hv)      g = 2;
        else              g = 0;
        chk("host_ready", 32'(host_ready), 32'(g >= 2));
        chk("mem_en", 32'(mem_en), 32'(g != 0));
        chk("mem_we", 32'(mem_we), 32'(g >= 2 && hwe));
        if (g == 1) chk("mem_addr_disp", 32'(mem_addr), 32'(da));
        if (g >= 2) chk("mem_addr_host", 32'(mem_addr), 32'(ha));
        if (g >= 2 && hwe) chk("mem_wdata", 32'(mem_wdata), 32'(hwd));
        if (host_ready) ready_seen++;

        if (g == 1) begin
            d.due = cyc + 2; d.drop = 0; d.data = rd_ref(da);
            dq.push_back(d);
        end
        if (g == 3 && dr) begin
            d.due = cyc + 2; d.drop = 1; d.data = '0;
            dq.push_back(d);
        end
        if (g >= 2) begin
            if (hwe) ref_mem[int'(ha[7:0])] = hwd;
            else begin
                h.due = cyc + 2; h.data = rd_ref(ha);
                hq.push_back(h);
            end
        end
        if (clr) under_m = '0;
        else if (g == 3 && dr && under_m != 16'hFFFF) under_m = under_m + 16'd1;
        if (!hv) begin
            wcnt_m = 0; pend_m = 0;
        end else if (g >= 2) begin
            wcnt_m = 0; pend_m = 0;
        end else begin
            if (wcnt_m == MW - 1) pend_m = 1;
            wcnt_m++;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, '0, 0, 0, '0, '0, 0);
    endtask

    // Host write held against continuous display traffic until it is forced through.
    task automatic starve(input bit clr_on_force);
        for (int i = 0; i < MW + 1; i++)
            step(0, 1, AW'(i), 1, 1, AW'(8'h40), 16'h1234, clr_on_force && (i == MW));
        step(0, 1, AW'(8'h50), 0, 0, '0, '0, 0);
        idle(2);
    endtask

    initial begin
        reset = 1; disp_req = 0; disp_addr = '0; host_valid = 0; host_we = 0;
        host_addr = '0; host_wdata = '0; clr_stats = 0;
        step(1, 0, '0, 0, 0, '0, '0, 0);
        step(1, 0, '0, 0, 0, '0, '0, 0);

        // Back-to-back display reads
        ready_seen = 0; obs_disp.delete();
        step(0, 1, AW'(8'h10), 0, 0, '0, '0, 0);
        step(0, 1, AW'(8'h11), 0, 0, '0, '0, 0);
        step(0, 1, AW'(8'h12), 0, 0, '0, '0, 0);
        idle(3);
        chk("r21_count", 32'(obs_disp.size()), 3);
        if (obs_disp.size() == 3) begin
            chk("r21_d0", 32'(obs_disp[0]), 32'h110);
            chk("r21_d1", 32'(obs_disp[1]), 32'h111);
            chk("r21_d2", 32'(obs_disp[2]), 32'h112);
        end
        chk("r21_ready", 32'(ready_seen), 0);

        // Host write then read-back
        ready_seen = 0; obs_host.delete();
        step(0, 0, '0, 1, 1, AW'(8'h20), 16'hBEEF, 0);
        step(0, 0, '0, 1, 0, AW'(8'h20), '0, 0);
        idle(3);
        chk("r22_ready", 32'(ready_seen), 2);
        chk("r22_count", 32'(obs_host.size()), 1);
        if (obs_host.size() == 1) chk("r22_rdata", 32'(obs_host[0]), 32'hBEEF);

        // Starved host read forced through continuous display
        step(1, 0, '0, 0, 0, '0, '0, 0);
        ready_seen = 0; obs_disp.delete();
        for (int i = 0; i < MW + 1; i++)
            step(0, 1, AW'(8'h60 + i), 1, 0, AW'(8'h30), '0, 0);
        chk("r23_ready_after_wait", 32'(ready_seen), 1);
        step(0, 1, AW'(8'h80), 0, 0, '0, '0, 0);
        idle(3);
        chk("r23_ready", 32'(ready_seen), 1);
        chk("r23_underrun", 32'(underrun_cnt), 1);
        chk("r23_slots", 32'(obs_disp.size()), MW + 2);
        if (obs_disp.size() == MW + 2)
            chk("r23_repeat", 32'(obs_disp[MW]), 32'(obs_disp[MW-1]));

        // Reset one cycle after a host read grant discards the response
        obs_host.delete();
        step(0, 0, '0, 1, 0, AW'(8'h21), '0, 0);
        step(1, 0, '0, 0, 0, '0, '0, 0);
        step(1, 0, '0, 0, 0, '0, '0, 0);
        idle(4);
        chk("r25_no_rvalid", 32'(obs_host.size()), 0);

        // Saturation and clear priority
        force dut.underrun_cnt_reg = 16'hFFFE;
        #1;
        release dut.underrun_cnt_reg;
        under_m = 16'hFFFE;
        starve(0);
        chk("r24_ffff", 32'(underrun_cnt), 32'hFFFF);
        starve(0);
        chk("r24_sat", 32'(underrun_cnt), 32'hFFFF);
        starve(1);
        chk("r24_clr", 32'(underrun_cnt), 0);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 199) == 0),
                 ($urandom_range(0, 99) < 55),
                 AW'($urandom_range(0, 255)),
                 ($urandom_range(0, 99) < 60),
                 ($urandom_range(0, 1) == 1),
                 AW'($urandom_range(0, 255)),
                 DW'($urandom),
                 ($urandom_range(0, 49) == 0));
        end
        idle(3);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
